// File: rtl/lcg_ctrl_pkg.sv
// Shared constants and state encoding for the bit-serial LCG controller.
package lcg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int         W_DEF      = 8;
  localparam logic [7:0] MULT_A_DEF = 8'd5;
  localparam logic [7:0] INC_C_DEF  = 8'd3;

endpackage

// File: rtl/lcg_serial_ctrl_fa_bit.sv
// Single-bit full adder; the only arithmetic element of the serial LCG.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/lcg_serial_ctrl.sv
// Bit-serial LCG step x' = (MULT_A*x + INC_C) mod 2^W, one accumulator bit per cycle.
//   state | meaning
//   IDLE  | waiting for seed_we or start
//   RUN   | shift-and-add passes: p<W adds MULT_A[p]*x<<p, p=W adds INC_C
//   HOLD  | result in x, out_valid raised, waiting for out_ready
module lcg_serial_ctrl
  import lcg_ctrl_pkg::*;
#(
  parameter int           W      = W_DEF,
  parameter logic [W-1:0] MULT_A = W'(MULT_A_DEF),
  parameter logic [W-1:0] INC_C  = W'(INC_C_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_we,
  input  logic [W-1:0] seed,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rnd_out
);

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] PW   = CW'(W);

  state_e        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] p_q, p_d;
  logic [CW-1:0] b_q, b_d;
  logic          carry_q, carry_d;
  logic          out_valid_q, out_valid_d;

  logic mult_bit, x_bit, inc_bit;
  logic fa_a, fa_b, fa_sum, fa_cout;

  // Operand bit for accumulator position b: x[b-p] gated by MULT_A[p], or INC_C[b] on the last pass.
  always_comb begin
    mult_bit = 1'b0;
    x_bit    = 1'b0;
    inc_bit  = 1'b0;
    fa_a     = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == int'(p_q)) mult_bit = MULT_A[i];
      if (i == int'(b_q) - int'(p_q)) x_bit = x_q[i];
      if (i == int'(b_q)) begin
        inc_bit = INC_C[i];
        fa_a    = acc_q[i];
      end
    end
    fa_b = (p_q == PW) ? inc_bit : (mult_bit & x_bit);
  end

  fa_bit u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    p_d         = p_q;
    b_d         = b_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_we) begin
          x_d = seed;
        end else if (start) begin
          acc_d   = '0;
          p_d     = '0;
          b_d     = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < W; i++) begin
          if (i == int'(b_q)) acc_d[i] = fa_sum;
        end
        // Carry out of the top bit is dropped so the next pass starts clean.
        carry_d = (b_q == LAST) ? 1'b0 : fa_cout;
        if (b_q == LAST) begin
          b_d = '0;
          if (p_q == PW) begin
            state_d = HOLD;
            x_d     = acc_d;
          end else begin
            p_d = p_q + CW'(1);
          end
        end else begin
          b_d = b_q + CW'(1);
        end
      end
      HOLD: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign rnd_out   = x_q;

endmodule

// File: tb/tb_lcg_serial_ctrl.sv
// Scoreboard bench for lcg_serial_ctrl: arithmetic LCG model feeds expected queues, a monitor checks results.
module tb_lcg_serial_ctrl;

  localparam int W   = 8;
  localparam int A   = 5;
  localparam int C   = 3;
  localparam int MOD = 1 << W;
  localparam int LAT = W * (W + 1) + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         seed_we = 1'b0;
  logic [W-1:0] seed = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] rnd_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_x = 0;
  int last_exp = 0;
  int exp_q[$];
  int start_q[$];
  logic ov_prev = 1'b0;

  lcg_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_we   (seed_we),
    .seed      (seed),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rnd_out   (rnd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (start_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc - start_q.pop_front(), LAT);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else chk("rnd_out", int'(rnd_out), exp_q.pop_front());
      end
      ov_prev = out_valid;
    end
  end

  task automatic seed_load(input int v);
    seed_we = 1'b1;
    seed    = W'(v);
    @(posedge clk); #1;
    seed_we = 1'b0;
    model_x = v;
    chk("seed_load", int'(rnd_out), v);
  endtask

  task automatic issue_start();
    model_x  = (A * model_x + C) % MOD;
    last_exp = model_x;
    exp_q.push_back(model_x);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_q.push_back(cyc);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < LAT + 20; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("valid_wait", int'(out_valid), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < LAT + 40; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  task automatic run_step(input int ready_dly);
    out_ready = (ready_dly == 0);
    issue_start();
    wait_valid();
    repeat (ready_dly) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    out_ready = 1'b0;
  endtask

  initial begin
    int first_ret;
    rst_n = 1'b0;
    #12;
    chk("reset_rnd", int'(rnd_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // seed=1 then three steps: 8, 43, 218
    seed_load(1);
    for (int k = 0; k < 3; k++) run_step(0);
    chk("seq_third", int'(rnd_out), 218);

    seed_load(0);
    run_step(0);
    seed_load(255);
    run_step(0);

    // Stalled consumer with stray start/seed pulses during HOLD
    seed_load(9);
    out_ready = 1'b0;
    issue_start();
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_busy", int'(busy), 1);
      chk("hold_rnd", int'(rnd_out), last_exp);
      start   = 1'($urandom_range(0, 1));
      seed_we = 1'($urandom_range(0, 1));
      seed    = W'($urandom);
      @(posedge clk); #1;
    end
    start   = 1'b0;
    seed_we = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    out_ready = 1'b0;
    run_step(0);

    // Seed wins over start in the same IDLE cycle
    seed_we = 1'b1;
    start   = 1'b1;
    seed    = W'(7);
    @(posedge clk); #1;
    seed_we = 1'b0;
    start   = 1'b0;
    model_x = 7;
    chk("prio_rnd", int'(rnd_out), 7);
    chk("prio_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("prio_still_idle", int'(busy), 0);

    // Asynchronous reset in the middle of RUN
    seed_load(100);
    out_ready = 1'b1;
    issue_start();
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rnd", int'(rnd_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(out_valid), 0);
    exp_q.delete();
    start_q.delete();
    model_x = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_step(0);
    chk("after_reset", int'(rnd_out), 3);

    // Randomized seeds and consumer delays
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0) seed_load(int'($urandom_range(0, MOD - 1)));
      run_step(int'($urandom_range(0, 6)));
    end

    // Full-period run from seed 1
    seed_load(1);
    first_ret = 0;
    for (int k = 1; k <= MOD; k++) begin
      run_step(0);
      if (rnd_out == W'(1) && first_ret == 0) first_ret = k;
    end
    chk("period", first_ret, MOD);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size() + start_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcg_serial_ctrl.md
LCG_SERIAL_CTRL -- requirements
Module: lcg_serial_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, state/output word width (2..16).
REQ-002 SHALL have parameter MULT_A, default 8'd5, LCG multiplier, W bits.
REQ-003 SHALL have parameter INC_C, default 8'd3, LCG increment, W bits.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port seed_we  input  1  load seed into state register.
REQ-007 SHALL have port seed  input  W  seed value.
REQ-008 SHALL have port start  input  1  request one LCG step.
REQ-009 SHALL have port busy  output  1  high while a step is computing or a result awaits acceptance.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rnd_out  output  W  current state word x.

Function
REQ-013 SHALL compute x_next = (MULT_A*x + INC_C) mod 2^W using exactly one 1-bit full adder plus one carry flip-flop (bit-serial, LSB first).
REQ-014 SHALL use states IDLE, RUN, HOLD.
REQ-015 SHALL, in IDLE with seed_we=1, load x <= seed; start is ignored that same cycle (seed priority).
REQ-016 SHALL, in IDLE with start=1 and seed_we=0, clear accumulator, pass counter p=0, bit counter b=0, carry=0, and enter RUN.
REQ-017 SHALL, in RUN, run W+1 passes of W cycles each; pass p<W adds operand bit (MULT_A[p] ? x[b-p] : 0, 0 when b<p) to accumulator bit b; pass W adds INC_C[b].
REQ-018 SHALL clear the carry flip-flop at the start of every pass; carry out of bit W-1 is discarded (mod 2^W).
REQ-019 SHALL increment b each RUN cycle, wrap b to 0 and increment p at b=W-1; after p=W, b=W-1, enter HOLD and write x <= accumulator.
REQ-020 SHALL make latency fixed: out_valid rises on edge W*(W+1)+1 after the edge sampling start (73 for W=8), independent of operand values.
REQ-021 SHALL, in HOLD, hold out_valid=1 and rnd_out stable until out_ready=1; on that edge, return to IDLE with out_valid=0.
REQ-022 SHALL ignore start and seed_we in RUN and HOLD (no queuing, no state corruption).
REQ-023 SHALL drive rnd_out = x at all times; x changes only on seed load or at RUN->HOLD.
REQ-024 SHALL drive busy=1 in RUN and HOLD, 0 in IDLE.
REQ-025 SHALL allow back-to-back steps: start in the IDLE cycle immediately after HOLD acceptance begins a new step.

Reset
REQ-026 SHALL on rst_n=0, asynchronously force state=IDLE, x=0, accumulator=0, p=0, b=0, carry=0, out_valid=0, busy=0, rnd_out=0.
REQ-027 SHALL on reset asserted mid-RUN or mid-HOLD abandon the step with no partial result written to x.
REQ-028 SHALL accept start or seed_we on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place state encoding (IDLE/RUN/HOLD) and default W/MULT_A/INC_C constants in shared package lcg_ctrl_pkg.
REQ-030 SHALL instantiate exactly one sub-module fa_bit (1-bit full adder: a, b, cin -> sum, cout) as the only arithmetic element.
REQ-031 SHALL size counters p and b to ceil(log2(W+1)) bits.

Verification
REQ-032 SHALL verify: reset, seed_we with seed=1, then start x3 with out_ready=1 -> rnd_out 8, 43, 218; each out_valid 73 edges after start.
REQ-033 SHALL verify: seed=0, start -> rnd_out=3; seed=255, start -> rnd_out=254 (wrap-around).
REQ-034 SHALL verify: out_ready=0 for 20 cycles after out_valid -> out_valid, rnd_out, busy held; start/seed_we pulses during hold have no effect.
REQ-035 SHALL verify: seed_we=1 and start=1 same IDLE cycle with seed=7 -> x=7, state stays IDLE, busy=0.
REQ-036 SHALL verify: rst_n pulsed low at RUN cycle 30 -> outputs 0 asynchronously, x=0; next start yields 3.
REQ-037 SHALL verify: seed=1, 256 consecutive steps -> sequence period 256 (full period for A=5, C=3), each step latency exactly 73.
